// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the FSM encoding and the instruction-word helpers.
package fetch_pkg;

  localparam int DATA_W     = 16;
  localparam int PC_W       = 16;
  localparam int CNT_W      = 4;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;

  localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } fetch_state_t;

  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcodeOf(input logic [DATA_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  // The full PC is compared, so addresses beyond the memory fault instead of wrapping.
  function automatic logic pcOutOfRange(input logic [PC_W-1:0] pc, input int addrW);
    return (pc >> addrW) != '0;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous instruction RAM, write-first, one-cycle registered read.
// The read register only updates on a write or an explicit read, so its data stays put.
module imem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              CLOCK_50,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLOCK_50) begin
    if (we) begin
      mem[addr] <= wrData;
      rdData    <= wrData;
    end else if (re) begin
      rdData <= mem[addr];
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: programmable instruction memory with configurable wait states
// feeding a held instruction word to the multicycle core.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W      = 8,
  parameter int                 DATA_W      = 16,
  parameter int                 WAIT_STATES = 2,
  parameter logic [DATA_W-1:0]  NOP_INSTR   = fetch_pkg::NOP_INSTR
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [15:0]       pc_in,
  input  logic              fetch_req,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              busy,
  output logic              addr_fault,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_drop
);

  fetch_state_t state, stateNext;

  logic [15:0]       addrQ, addrNext;
  logic [CNT_W-1:0]  waitCnt, waitCntNext;
  logic [DATA_W-1:0] instrReg;
  logic              instrValidReg;
  logic              addrFaultReg;
  logic              busyReg;
  logic              progDropReg;

  logic              issueRead;
  logic              pcFault;
  logic              ramWe;
  logic              ramRe;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramData;
  logic [DATA_W-1:0] respWord;

  // The program port owns the RAM only while idle; otherwise the fetch address drives it.
  assign ramWe   = (state == IDLE) && prog_we;
  assign ramRe   = issueRead;
  assign ramAddr = ramWe ? prog_addr : addrQ[ADDR_W-1:0];

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) uRam (
    .CLOCK_50 (CLOCK_50),
    .we       (ramWe),
    .re       (ramRe),
    .addr     (ramAddr),
    .wrData   (prog_data),
    .rdData   (ramData)
  );

  assign pcFault  = pcOutOfRange(addrQ, ADDR_W);
  assign respWord = pcFault ? NOP_INSTR : ramData;

  always_comb begin
    stateNext   = state;
    addrNext    = addrQ;
    waitCntNext = waitCnt;
    issueRead   = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_req) begin
          stateNext   = WAIT;
          addrNext    = pc_in;
          waitCntNext = CNT_W'(WAIT_STATES);
        end
      end
      WAIT: begin
        if (waitCnt == '0) begin
          issueRead = 1'b1;
          stateNext = RESP;
        end else begin
          waitCntNext = waitCnt - 4'd1;
        end
      end
      RESP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state         <= IDLE;
      addrQ         <= '0;
      waitCnt       <= '0;
      instrReg      <= '0;
      instrValidReg <= 1'b0;
      addrFaultReg  <= 1'b0;
      busyReg       <= 1'b0;
      progDropReg   <= 1'b0;
    end else begin
      state         <= stateNext;
      addrQ         <= addrNext;
      waitCnt       <= waitCntNext;
      instrValidReg <= issueRead;
      addrFaultReg  <= issueRead && pcFault;
      busyReg       <= (stateNext == WAIT);
      progDropReg   <= prog_we && (state != IDLE);
      if (state == RESP) begin
        instrReg <= respWord;
      end
    end
  end

  // During the response cycle the fresh word is presented straight from the RAM read
  // register so it lines up with instr_valid; afterwards the held copy takes over.
  assign instruction = (state == RESP) ? respWord : instrReg;
  assign instr_valid = instrValidReg;
  assign addr_fault  = addrFaultReg;
  assign busy        = busyReg;
  assign prog_drop   = progDropReg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios then randomized fetches
// compared cycle by cycle against a memory-array reference model.
module tb_instr_fetch_unit;

  localparam int WS    = 2;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic        CLOCK_50;
  logic        reset;
  logic [15:0] pc_in;
  logic        fetch_req;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        busy;
  logic        addr_fault;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic        prog_drop;

  int total = 0;
  int bad   = 0;

  logic [15:0] refMem [DEPTH];
  logic [15:0] lastInstr;

  instr_fetch_unit #(
    .ADDR_W      (AW),
    .DATA_W      (16),
    .WAIT_STATES (WS),
    .NOP_INSTR   (16'h0000)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .pc_in       (pc_in),
    .fetch_req   (fetch_req),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .busy        (busy),
    .addr_fault  (addr_fault),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_drop   (prog_drop)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #5000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic progWrite(input logic [7:0] addr, input logic [15:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    refMem[addr] = data;
    @(negedge CLOCK_50);
    prog_we = 1'b0;
  endtask

  // One fetch accepted at cycle T, then every cycle T+1..T+WS+6 is checked against the
  // expected timeline: busy while waiting, one valid at T+WS+2, held word otherwise.
  task automatic fetchTxn(input logic [15:0] pc, input bit hold, input int injK,
                          input logic [7:0] injAddr, input logic [15:0] injData,
                          input bit simW, input logic [15:0] simData);
    logic [15:0] expWord;
    logic [7:0]  lowAddr;
    logic        expFault;
    lowAddr = pc[7:0];
    if (simW) begin
      prog_we   = 1'b1;
      prog_addr = lowAddr;
      prog_data = simData;
      refMem[lowAddr] = simData;
    end else begin
      prog_we = 1'b0;
    end
    fetch_req = 1'b1;
    pc_in     = pc;
    expFault  = (pc >= 16'(DEPTH));
    expWord   = expFault ? 16'h0000 : refMem[lowAddr];
    for (int k = 1; k <= WS + 6; k++) begin
      @(negedge CLOCK_50);
      chk1("instr_valid", instr_valid, k == WS + 2);
      chk1("busy", busy, k <= WS + 1);
      chk1("addr_fault", addr_fault, (k == WS + 2) && expFault);
      chk1("prog_drop", prog_drop, (injK != 0) && (k == injK + 1));
      chk16("instruction", instruction, (k < WS + 2) ? lastInstr : expWord);
      fetch_req = hold && (k <= WS + 2);
      pc_in     = 16'($urandom);
      prog_we   = (injK == k);
      prog_addr = injAddr;
      prog_data = injData;
    end
    lastInstr = expWord;
    $display("fetch pc=%h word=%h fault=%0d hold=%0d inj=%0d simw=%0d", pc, expWord, expFault,
             hold, injK, simW);
  endtask

  initial begin
    reset     = 1'b1;
    pc_in     = '0;
    fetch_req = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    lastInstr = 16'h0000;
    repeat (3) @(negedge CLOCK_50);
    chk16("reset_instruction", instruction, 16'h0000);
    chk1("reset_valid", instr_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_fault", addr_fault, 1'b0);
    chk1("reset_drop", prog_drop, 1'b0);
    reset = 1'b0;
    @(negedge CLOCK_50);

    for (int a = 0; a < DEPTH; a++) begin
      progWrite(8'(a), 16'($urandom));
    end
    chk1("preload_drop", prog_drop, 1'b0);
    progWrite(8'h00, 16'h1234);
    progWrite(8'h01, 16'hA5F0);

    // Directed scenarios.
    fetchTxn(16'h0001, 1'b0, 0, 8'h00, 16'h0000, 1'b0, 16'h0000);
    fetchTxn(16'h0000, 1'b1, 0, 8'h00, 16'h0000, 1'b0, 16'h0000);
    fetchTxn(16'h0100, 1'b0, 0, 8'h00, 16'h0000, 1'b0, 16'h0000);
    fetchTxn(16'h0005, 1'b0, 1, 8'h05, 16'hFFFF, 1'b0, 16'h0000);
    fetchTxn(16'h0005, 1'b0, 0, 8'h00, 16'h0000, 1'b0, 16'h0000);
    fetchTxn(16'h0007, 1'b0, 0, 8'h00, 16'h0000, 1'b1, 16'hBEEF);

    // Reset two cycles into a fetch aborts it and clears the held word.
    fetch_req = 1'b1;
    pc_in     = 16'h0001;
    @(negedge CLOCK_50);
    fetch_req = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk1("abort_valid", instr_valid, 1'b0);
      chk1("abort_busy", busy, 1'b0);
      chk16("abort_instruction", instruction, 16'h0000);
      @(negedge CLOCK_50);
    end
    lastInstr = 16'h0000;
    $display("reset mid-fetch pc=0001");
    fetchTxn(16'h0000, 1'b0, 0, 8'h00, 16'h0000, 1'b0, 16'h0000);

    // Randomized fetches with occasional idle writes, dropped writes and held requests.
    for (int n = 0; n < 40; n++) begin
      logic [15:0] pc;
      int          sel;
      int          injK;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      pc = 16'h0100;
      else if (sel == 1) pc = 16'($urandom_range(257, 65535));
      else if (sel == 2) pc = 16'h00FF;
      else               pc = 16'($urandom_range(0, 255));
      injK = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, WS + 2)) : 0;
      if ($urandom_range(0, 3) == 0) begin
        progWrite(8'($urandom), 16'($urandom));
      end
      fetchTxn(pc, 1'($urandom_range(0, 1)), injK, 8'($urandom), 16'($urandom),
               ($urandom_range(0, 4) == 0), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
